// File: rtl/bcd_pkg.sv
// Definitions shared by the BCD converter arbiter and the converter it fronts,
// so that every instance agrees on widths and state encodings.
package bcd_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam int DEFAULT_INPUT_WIDTH    = 24;
  localparam int DEFAULT_DECIMAL_DIGITS = 6;

  // Worst-case start-to-DV latency of the 24-bit/6-digit converter; TIMEOUT_CYCLES
  // must be larger than this in a real system or good conversions get aborted.
  localparam int CONV_WORST_LATENCY = 330;

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester and converter signals of the BCD converter arbiter. The arbiter
// connects through the slave modport; the surrounding system uses master.
interface bcd_conv_arbiter_if #(
  parameter int NUM_REQ        = 2,
  parameter int INPUT_WIDTH    = 24,
  parameter int DECIMAL_DIGITS = 6
);

  logic [NUM_REQ-1:0]             i_Req;
  logic [NUM_REQ*INPUT_WIDTH-1:0] i_Binary;
  logic [NUM_REQ-1:0]             o_Ack;
  logic [NUM_REQ-1:0]             o_DV;
  logic [NUM_REQ-1:0]             o_Err;
  logic [DECIMAL_DIGITS*4-1:0]    o_BCD;
  logic                           o_Busy;
  logic                           o_Conv_Start;
  logic [INPUT_WIDTH-1:0]         o_Conv_Binary;
  logic [DECIMAL_DIGITS*4-1:0]    i_Conv_BCD;
  logic                           i_Conv_DV;

  modport slave (
    input  i_Req, i_Binary, i_Conv_BCD, i_Conv_DV,
    output o_Ack, o_DV, o_Err, o_BCD, o_Busy, o_Conv_Start, o_Conv_Binary
  );

  modport master (
    output i_Req, i_Binary, i_Conv_BCD, i_Conv_DV,
    input  o_Ack, o_DV, o_Err, o_BCD, o_Busy, o_Conv_Start, o_Conv_Binary
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or above
// the pointer, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] pointer_i,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate down so the one nearest the pointer wins.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_o = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(pointer_i) + i) % NUM_REQ);
      if (req_i[cand]) idx_o = cand;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one single-shot binary-to-BCD converter between NUM_REQ requesters:
// round-robin grant, one-cycle launch, bounded wait, one-hot result delivery.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int INPUT_WIDTH    = DEFAULT_INPUT_WIDTH,
  parameter int DECIMAL_DIGITS = DEFAULT_DECIMAL_DIGITS,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic               i_Clock,
  input logic               i_Rst_L,
  bcd_conv_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BCD_W = DECIMAL_DIGITS * 4;

  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [NUM_REQ-1:0]     dv_q, dv_d;
  logic [NUM_REQ-1:0]     err_q, err_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   start_q, start_d;
  logic [INPUT_WIDTH-1:0] bin_q, bin_d;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [INPUT_WIDTH-1:0] operand [NUM_REQ];
  logic [NUM_REQ-1:0]     owner_oh;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_operand
    assign operand[k] = bus.i_Binary[k*INPUT_WIDTH +: INPUT_WIDTH];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i     (bus.i_Req),
    .pointer_i (ptr_q),
    .idx_o     (pick_idx),
    .any_o     (pick_any)
  );

  assign owner_oh = NUM_REQ'(1) << owner_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    ack_d   = '0;
    dv_d    = '0;
    err_d   = '0;
    start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          ack_d   = NUM_REQ'(1) << pick_idx;
          start_d = 1'b1;
          bin_d   = operand[pick_idx];
          owner_d = pick_idx;
          // Advancing at grant keeps a requester whose conversion times out from
          // being picked again ahead of the others.
          ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_Conv_DV) begin
          bcd_d   = bus.i_Conv_BCD;
          dv_d    = owner_oh;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = owner_oh;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: data registers (bcd_q, bin_q) are reset along with control because the outputs they drive must read 0 out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      dv_q    <= '0;
      err_q   <= '0;
      bcd_q   <= '0;
      start_q <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      bcd_q   <= bcd_d;
      start_q <= start_d;
      bin_q   <= bin_d;
    end
  end

  assign bus.o_Ack         = ack_q;
  assign bus.o_DV          = dv_q;
  assign bus.o_Err         = err_q;
  assign bus.o_BCD         = bcd_q;
  assign bus.o_Busy        = (state_q == S_WAIT);
  assign bus.o_Conv_Start  = start_q;
  assign bus.o_Conv_Binary = bin_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: behavioural converter model plus a
// round-robin reference model, randomized operands and converter latencies.
module tb_bcd_conv_arbiter;

  localparam int NR = 2;
  localparam int IW = 24;
  localparam int DD = 6;
  localparam int BW = DD * 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_conv_arbiter_if #(.NUM_REQ(NR), .INPUT_WIDTH(IW), .DECIMAL_DIGITS(DD)) bus ();

  bcd_conv_arbiter #(
    .NUM_REQ(NR), .INPUT_WIDTH(IW), .DECIMAL_DIGITS(DD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: round-robin pointer, last delivered BCD, requester operands.
  int          ref_ptr = 0;
  logic [BW-1:0] ref_bcd = '0;
  logic [IW-1:0] operand [NR];
  int          conv_lat = 1;  // -1 means the converter never answers

  function automatic logic [BW-1:0] to_bcd(input logic [IW-1:0] v);
    logic [BW-1:0] r;
    int n;
    r = '0;
    n = int'(v);
    for (int d = 0; d < DD; d++) begin
      r[d*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic int ref_pick(input logic [NR-1:0] mask);
    for (int i = 0; i < NR; i++) begin
      if (mask[(ref_ptr + i) % NR]) return (ref_ptr + i) % NR;
    end
    return -1;
  endfunction

  function automatic int oh_index(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data();
    for (int i = 0; i < NR; i++) bus.i_Binary[i*IW +: IW] = operand[i];
  endtask

  // Converter model: after a start it waits conv_lat cycles, then pulses DV for
  // one cycle with the decimal digits of the operand it was launched with.
  initial begin : conv_model
    logic [IW-1:0] op;
    int lat;
    forever begin
      tick();
      if (bus.o_Conv_Start === 1'b1 && conv_lat >= 0) begin
        op  = bus.o_Conv_Binary;
        lat = conv_lat;
        for (int i = 0; i < lat; i++) tick();
        bus.i_Conv_BCD = to_bcd(op);
        bus.i_Conv_DV  = 1'b1;
        tick();
        bus.i_Conv_DV  = 1'b0;
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.i_Req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    ref_ptr = 0;
    ref_bcd = '0;
    tick();
  endtask

  // One full transaction from the current i_Req: grant, launch, delivery or abort.
  task automatic serve_one(input int lat, input logic [NR-1:0] hold, output int granted);
    int exp_idx, exp_k, k;
    logic [NR-1:0] exp_oh;
    logic [IW-1:0] exp_op;
    bit exp_dv;
    exp_idx = ref_pick(bus.i_Req);
    exp_oh  = NR'(1) << exp_idx;
    exp_op  = operand[exp_idx];
    exp_dv  = (lat >= 0 && lat < TO);
    exp_k   = exp_dv ? lat + 1 : TO;
    conv_lat = lat;
    tick();
    granted = oh_index(bus.o_Ack);
    n_checks++;
    if (bus.o_Ack !== exp_oh) begin
      n_errors++;
      $display("FAIL grant_ack: got %b expected %b", bus.o_Ack, exp_oh);
    end
    n_checks++;
    if (bus.o_Conv_Start !== 1'b1 || bus.o_Busy !== 1'b1) begin
      n_errors++;
      $display("FAIL launch: start=%b busy=%b expected 1 1", bus.o_Conv_Start, bus.o_Busy);
    end
    n_checks++;
    if (bus.o_Conv_Binary !== exp_op) begin
      n_errors++;
      $display("FAIL conv_operand: got %0d expected %0d", bus.o_Conv_Binary, exp_op);
    end
    ref_ptr = (exp_idx + 1) % NR;
    bus.i_Req = bus.i_Req & (hold | ~exp_oh);
    k = 0;
    do begin
      tick();
      k++;
      if (k == 1) begin
        n_checks++;
        if (bus.o_Ack !== '0 || bus.o_Conv_Start !== 1'b0) begin
          n_errors++;
          $display("FAIL pulse_width: ack=%b start=%b expected 0 0", bus.o_Ack, bus.o_Conv_Start);
        end
      end
    end while (bus.o_DV === '0 && bus.o_Err === '0 && k < 3 * TO);
    n_checks++;
    if (k != exp_k) begin
      n_errors++;
      $display("FAIL finish_latency: got %0d cycles expected %0d", k, exp_k);
    end
    if (exp_dv) ref_bcd = to_bcd(exp_op);
    n_checks++;
    if (bus.o_DV !== (exp_dv ? exp_oh : '0) || bus.o_Err !== (exp_dv ? '0 : exp_oh)) begin
      n_errors++;
      $display("FAIL finish_kind: dv=%b err=%b expected dv=%b err=%b", bus.o_DV, bus.o_Err,
               exp_dv ? exp_oh : '0, exp_dv ? '0 : exp_oh);
    end
    n_checks++;
    if (bus.o_BCD !== ref_bcd || bus.o_Busy !== 1'b0) begin
      n_errors++;
      $display("FAIL result: bcd=%h busy=%b expected %h 0", bus.o_BCD, bus.o_Busy, ref_bcd);
    end
  endtask

  task automatic test_reset();
    bus.i_Req = '0;
    bus.i_Binary = '0;
    bus.i_Conv_BCD = '0;
    bus.i_Conv_DV = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.o_Ack !== '0 || bus.o_DV !== '0 || bus.o_Err !== '0) begin
      n_errors++;
      $display("FAIL reset_pulses: ack=%b dv=%b err=%b expected all 0", bus.o_Ack, bus.o_DV, bus.o_Err);
    end
    n_checks++;
    if (bus.o_BCD !== '0 || bus.o_Conv_Binary !== '0) begin
      n_errors++;
      $display("FAIL reset_data: bcd=%h bin=%h expected 0", bus.o_BCD, bus.o_Conv_Binary);
    end
    n_checks++;
    if (bus.o_Busy !== 1'b0 || bus.o_Conv_Start !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: busy=%b start=%b expected 0 0", bus.o_Busy, bus.o_Conv_Start);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int g;
    apply_reset();
    operand[0] = 24'd123456;
    operand[1] = 24'd0;
    set_data();
    bus.i_Req = 2'b01;
    serve_one(int'($urandom_range(1, 10)), 2'b00, g);
    n_checks++;
    if (bus.o_DV !== 2'b01 || bus.o_BCD !== 24'h123456) begin
      n_errors++;
      $display("FAIL single_result: dv=%b bcd=%h expected 01 123456", bus.o_DV, bus.o_BCD);
    end
  endtask

  task automatic test_contention();
    int g;
    logic [NR-1:0] exp_dv [3];
    logic [BW-1:0] exp_bcd [3];
    exp_dv[0] = 2'b01;  exp_bcd[0] = 24'h000042;
    exp_dv[1] = 2'b10;  exp_bcd[1] = 24'h999999;
    exp_dv[2] = 2'b01;  exp_bcd[2] = 24'h000042;
    apply_reset();
    operand[0] = 24'd42;
    operand[1] = 24'd999999;
    set_data();
    bus.i_Req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      serve_one(int'($urandom_range(0, 12)), 2'b11, g);
      n_checks++;
      if (bus.o_DV !== exp_dv[i] || bus.o_BCD !== exp_bcd[i]) begin
        n_errors++;
        $display("FAIL contention_%0d: dv=%b bcd=%h expected %b %h", i, bus.o_DV, bus.o_BCD,
                 exp_dv[i], exp_bcd[i]);
      end
    end
    bus.i_Req = '0;
    tick();
  endtask

  task automatic test_fairness();
    int g, last;
    apply_reset();
    last = -1;
    bus.i_Req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      serve_one(int'($urandom_range(0, 14)), 2'b10, g);
      bus.i_Req[0] = 1'b1;
      n_checks++;
      if (g == last || g < 0) begin
        n_errors++;
        $display("FAIL fairness_%0d: granted %0d, previous %0d, expected the other requester", i, g, last);
      end
      last = g;
      if (g >= 0) operand[g] = IW'($urandom_range(0, 999999));
      set_data();
    end
    bus.i_Req = '0;
    tick();
  endtask

  task automatic test_timeout();
    int g;
    apply_reset();
    operand[0] = IW'($urandom_range(0, 999999));
    operand[1] = IW'($urandom_range(1, 999999));
    set_data();
    bus.i_Req = 2'b10;
    serve_one(3, 2'b00, g);
    bus.i_Req = 2'b01;
    serve_one(-1, 2'b01, g);
    bus.i_Req = 2'b11;
    serve_one(2, 2'b01, g);
    n_checks++;
    if (g != 1) begin
      n_errors++;
      $display("FAIL after_timeout_grant: got %0d expected 1", g);
    end
    bus.i_Req = '0;
    tick();
  endtask

  task automatic test_dv_on_timeout();
    int g;
    apply_reset();
    operand[0] = IW'($urandom_range(0, 999999));
    set_data();
    bus.i_Req = 2'b01;
    serve_one(TO - 1, 2'b00, g);
    tick();
    n_checks++;
    if (bus.o_Err !== '0 || bus.o_DV !== '0) begin
      n_errors++;
      $display("FAIL dv_wins_followup: err=%b dv=%b expected 00 00", bus.o_Err, bus.o_DV);
    end
  endtask

  task automatic test_back_to_back();
    int g;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < NR; r++) if (!bus.i_Req[r]) operand[r] = IW'($urandom_range(0, 999999));
      set_data();
      bus.i_Req = bus.i_Req | NR'($urandom_range(1, 3));
      serve_one(int'($urandom_range(0, TO)) - 1, NR'($urandom_range(0, 3)), g);
    end
    bus.i_Req = '0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int g;
    bit saw_out;
    apply_reset();
    operand[0] = IW'($urandom_range(1, 999999));
    set_data();
    conv_lat = 8;
    bus.i_Req = 2'b01;
    tick();
    n_checks++;
    if (bus.o_Ack !== 2'b01 || bus.o_Busy !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_grant: ack=%b busy=%b expected 01 1", bus.o_Ack, bus.o_Busy);
    end
    bus.i_Req = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_Ack, bus.o_DV, bus.o_Err, bus.o_BCD, bus.o_Busy, bus.o_Conv_Start, bus.o_Conv_Binary} !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: ack=%b busy=%b start=%b bin=%h expected all 0",
               bus.o_Ack, bus.o_Busy, bus.o_Conv_Start, bus.o_Conv_Binary);
    end
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    ref_ptr = 0;
    ref_bcd = '0;
    saw_out = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.o_DV !== '0 || bus.o_Err !== '0 || bus.o_Busy !== 1'b0) saw_out = 1'b1;
    end
    n_checks++;
    if (saw_out) begin
      n_errors++;
      $display("FAIL stale_dv: output activity seen after reset, expected none");
    end
    operand[0] = 24'd7;
    set_data();
    bus.i_Req = 2'b01;
    serve_one(int'($urandom_range(1, 10)), 2'b00, g);
    n_checks++;
    if (bus.o_DV !== 2'b01 || bus.o_BCD !== 24'h000007) begin
      n_errors++;
      $display("FAIL fresh_after_reset: dv=%b bcd=%h expected 01 000007", bus.o_DV, bus.o_BCD);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    operand[0] = '0;
    operand[1] = '0;
    bus.i_Conv_DV = 1'b0;
    bus.i_Conv_BCD = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_dv_on_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
